scan_ctrl_1x5: RTL and testbench

Sequencer that sits directly upstream of the 1-to-5 demultiplexer and drives its 3-bit select and enable. It steps round-robin through the channels enabled by a 5-bit mask, holds each channel for a programmable dwell time, and never emits the invalid select codes 5–7. It supports single-sweep and continuous modes, with a Done pulse at the end of each sweep.

---
 rtl/scan_ctrl_1x5_if.sv | 34 +++
 rtl/scan_ctrl_1x5.sv | 130 +++++++++++++
 tb/tb_scan_ctrl_1x5.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/scan_ctrl_1x5_if.sv
// Handshake/control bundle between the scan sequencer and its host.
// master: host drives Start/Stop/Continuous/Mask; slave: sequencer drives Sel/E/Busy/Done.
interface scan_ctrl_1x5_if;
   logic       Start;
   logic       Stop;
   logic       Continuous;
   logic [4:0] Mask;
   logic [2:0] Sel;
   logic       E;
   logic       Busy;
   logic       Done;

   modport master (
      output Start,
      output Stop,
      output Continuous,
      output Mask,
      input  Sel,
      input  E,
      input  Busy,
      input  Done
   );

   modport slave (
      input  Start,
      input  Stop,
      input  Continuous,
      input  Mask,
      output Sel,
      output E,
      output Busy,
      output Done
   );
endinterface

// File: rtl/scan_ctrl_1x5.sv
// Round-robin dwell sequencer driving the select/enable of a 1-to-5 demux.
// Ports: Clk, Rst_n (sync, active-low); bus (slave): Start/Stop/Continuous/Mask in, Sel/E/Busy/Done out.
module scan_ctrl_1x5 #(
   parameter int DWELL = 4,
   parameter int CNT_W = 8
) (
   input logic             Clk,
   input logic             Rst_n,
   scan_ctrl_1x5_if.slave  bus
);

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

   state_t           state, state_n;
   logic [2:0]       sel, sel_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             e, e_n;
   logic             busy, busy_n;
   logic             done, done_n;

   logic [2:0]       first_ch;
   logic [2:0]       next_ch;
   logic             has_next;
   logic             any_mask;

   // Lowest enabled channel; only meaningful when the mask is non-zero.
   function automatic logic [2:0] lowest(input logic [4:0] m);
      logic [2:0] r;
      r = 3'd0;
      for (int i = 4; i >= 0; i--) begin
         if (m[i]) r = 3'(i);
      end
      return r;
   endfunction

   // Lowest enabled channel strictly above cur; MSB flags that one exists.
   function automatic logic [3:0] above(input logic [4:0] m,
                                        input logic [2:0] cur);
      logic [3:0] r;
      r = 4'd0;
      for (int i = 4; i >= 0; i--) begin
         if (m[i] && (3'(i) > cur)) r = {1'b1, 3'(i)};
      end
      return r;
   endfunction

   always_comb begin
      any_mask = |bus.Mask;
      first_ch = lowest(bus.Mask);
      {has_next, next_ch} = above(bus.Mask, sel);
   end

   always_comb begin
      state_n = state;
      sel_n   = sel;
      cnt_n   = cnt;
      done_n  = 1'b0;

      unique case (state)
         IDLE: begin
            sel_n = 3'd0;
            cnt_n = '0;
            if (bus.Start && !bus.Stop && any_mask) begin
               state_n = ACTIVE;
               sel_n   = first_ch;
            end
         end
         ACTIVE: begin
            if (bus.Stop) begin
               // Abort wins over an end-of-sweep on the same cycle.
               state_n = IDLE;
               sel_n   = 3'd0;
               cnt_n   = '0;
            end else if (cnt == LAST) begin
               cnt_n = '0;
               if (has_next) begin
                  sel_n = next_ch;
               end else begin
                  done_n = 1'b1;
                  if (bus.Continuous && any_mask) begin
                     sel_n = first_ch;
                  end else begin
                     state_n = IDLE;
                     sel_n   = 3'd0;
                  end
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
            sel_n   = 3'd0;
            cnt_n   = '0;
         end
      endcase

      e_n    = (state_n == ACTIVE);
      busy_n = (state_n == ACTIVE);
   end

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state <= IDLE;
         sel   <= 3'd0;
         cnt   <= '0;
         e     <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         sel   <= sel_n;
         cnt   <= cnt_n;
         e     <= e_n;
         busy  <= busy_n;
         done  <= done_n;
      end
   end

   assign bus.Sel  = sel;
   assign bus.E    = e;
   assign bus.Busy = busy;
   assign bus.Done = done;

endmodule

// File: tb/tb_scan_ctrl_1x5.sv
// Vector-table bench for scan_ctrl_1x5.
// DWELL=4; one record per cycle.
module tb_scan_ctrl_1x5;

  typedef struct packed {
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       cont;
    logic [4:0] mask;
    logic [2:0] x_sel;
    logic       x_e;
    logic       x_busy;
    logic       x_done;
  } vec_t;

  logic Clk;
  logic Rst_n;

  scan_ctrl_1x5_if bus ();

  scan_ctrl_1x5 #(
    .DWELL (4),
    .CNT_W (8)
  ) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  vec_t  tbl[$];
  string lbl[$];
  int    n_checks;
  int    n_fail;
  bit    seen;

  task automatic add(
    input string      name,
    input logic       r,
    input logic       st,
    input logic       sp,
    input logic       ct,
    input logic [4:0] mk,
    input logic [2:0] xs,
    input logic       xe,
    input logic       xd
  );
    vec_t v;
    v.rst_n  = r;
    v.start  = st;
    v.stop   = sp;
    v.cont   = ct;
    v.mask   = mk;
    v.x_sel  = xs;
    v.x_e    = xe;
    v.x_busy = xe;
    v.x_done = xd;
    tbl.push_back(v);
    lbl.push_back(name);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: test did not finish");
    $finish;
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    Rst_n    = 1'b0;
    bus.Start      = 1'b0;
    bus.Stop       = 1'b0;
    bus.Continuous = 1'b0;
    bus.Mask       = 5'h00;

    add("reset", 0, 1, 0, 0, 5'h1F, 0, 0, 0);
    add("reset", 0, 1, 0, 0, 5'h1F, 0, 0, 0);
    add("rst_rel", 1, 0, 0, 0, 5'h1F, 0, 0, 0);

    for (int c = 1; c <= 20; c++)
      add("full", 1, (c == 1), 0, 0, 5'h1F,
          3'((c - 1) / 4), 1, 0);
    add("full_done", 1, 0, 0, 0, 5'h1F, 0, 0, 1);
    add("full_after", 1, 0, 0, 0, 5'h1F, 0, 0, 0);

    for (int c = 1; c <= 8; c++)
      add("sparse", 1, (c == 1), 0, 0, 5'b10100,
          (c <= 4) ? 3'd2 : 3'd4, 1, 0);
    add("sparse_done", 1, 0, 0, 0, 5'b10100, 0, 0, 1);
    add("sparse_after", 1, 0, 0, 0, 5'b10100, 0, 0, 0);

    for (int c = 1; c <= 25; c++)
      add("cont", 1, (c == 1), 0, 1, 5'b10001,
          (((c - 1) % 8) < 4) ? 3'd0 : 3'd4, 1,
          (c > 1) && ((c % 8) == 1));
    add("cont_stop", 1, 0, 1, 1, 5'b10001, 0, 0, 0);
    add("cont_idle", 1, 0, 0, 0, 5'b10001, 0, 0, 0);

    for (int c = 1; c <= 10; c++)
      add("stop_run", 1, (c == 1), 0, 0, 5'h1F,
          3'((c - 1) / 4), 1, 0);
    add("stop", 1, 0, 1, 0, 5'h1F, 0, 0, 0);
    for (int c = 0; c < 4; c++)
      add("stop_nodone", 1, 0, 0, 0, 5'h1F, 0, 0, 0);

    add("st_sp_idle", 1, 1, 1, 0, 5'h1F, 0, 0, 0);
    add("st_sp_idle", 1, 0, 0, 0, 5'h1F, 0, 0, 0);

    add("mask0", 1, 1, 0, 1, 5'h00, 0, 0, 0);
    add("mask0", 1, 0, 0, 1, 5'h00, 0, 0, 0);

    for (int c = 1; c <= 8; c++)
      add("mask_clr", 1, (c == 1), 0, 1,
          (c <= 6) ? 5'h1F : 5'h00,
          3'((c - 1) / 4), 1, 0);
    add("mask_clr_done", 1, 0, 0, 1, 5'h00, 0, 0, 1);
    add("mask_clr_idle", 1, 0, 0, 1, 5'h00, 0, 0, 0);

    for (int c = 1; c <= 4; c++)
      add("stop_end", 1, (c == 1), 0, 0, 5'b00001, 0, 1, 0);
    add("stop_end", 1, 0, 1, 0, 5'b00001, 0, 0, 0);
    add("stop_end", 1, 0, 0, 0, 5'b00001, 0, 0, 0);

    add("mid_rst", 1, 1, 0, 0, 5'b00110, 1, 1, 0);
    add("mid_rst", 1, 1, 0, 0, 5'b00110, 1, 1, 0);
    add("mid_rst", 0, 0, 0, 0, 5'b00110, 0, 0, 0);
    add("mid_rst", 1, 0, 0, 0, 5'b00110, 0, 0, 0);

    for (int k = 0; k < tbl.size(); k++) begin
      vec_t v;
      v = tbl[k];
      Rst_n          = v.rst_n;
      bus.Start      = v.start;
      bus.Stop       = v.stop;
      bus.Continuous = v.cont;
      bus.Mask       = v.mask;
      @(posedge Clk);
      #1;
      n_checks++;
      if ({bus.Sel, bus.E, bus.Busy, bus.Done} !==
          {v.x_sel, v.x_e, v.x_busy, v.x_done}) begin
        n_fail++;
        $display("FAIL %s vec %0d: got %0d/%b/%b/%b want %0d/%b/%b/%b",
                 lbl[k], k, bus.Sel, bus.E, bus.Busy, bus.Done,
                 v.x_sel, v.x_e, v.x_busy, v.x_done);
      end
    end

    Rst_n     = 1'b0;
    bus.Start = 1'b1;
    bus.Stop  = 1'b0;
    bus.Mask  = 5'h1F;
    @(posedge Clk);
    #1;
    n_checks++;
    if ({bus.Sel, bus.E, bus.Busy, bus.Done} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset state: got %0d/%b/%b/%b",
               bus.Sel, bus.E, bus.Busy, bus.Done);
    end

    Rst_n          = 1'b1;
    bus.Start      = 1'b1;
    bus.Continuous = 1'b0;
    bus.Mask       = 5'b00001;
    @(posedge Clk);
    #1;
    bus.Start = 1'b0;
    seen = 1'b0;
    for (int w = 0; w < 16 && !seen; w++) begin
      @(posedge Clk);
      #1;
      if (bus.Done) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL wait expired: no Done within 16 cycles");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
